uart_tx_feeder: RTL and testbench

//  Byte FIFO plus sequencer that sits directly upstream of uart_top's TX side.

---
 rtl/uart_tx_feeder.sv | 120 ++++++++++++
 tb/tb_uart_tx_feeder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// Byte FIFO and one-at-a-time sequencer feeding uart_top's transmit/tx_data,
// paced by the rising edge of tx_done, with a sticky timeout flag.
module uart_tx_feeder #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 2000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     transmit,
    output logic [7:0]               tx_data,
    input  logic                     tx_done,
    output logic                     busy,
    output logic                     tx_err,
    input  logic                     err_clr,
    output logic                     dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_DONE = 1'b1
    } state_t;

    state_t        state;
    state_t        state_d;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [TW-1:0] timer;
    logic          tx_done_q;
    logic          done_rise;
    logic          push;
    logic          pop;
    logic          timeout;

    // Handshake: transmit is a single-cycle start pulse with tx_data held until
    // the next pop; only a fresh 0->1 edge of tx_done completes the byte.
    assign full      = (count == (AW + 1)'(DEPTH));
    assign empty     = (count == '0);
    assign busy      = (state != IDLE) || !empty;
    assign done_rise = tx_done & ~tx_done_q;
    assign push      = wr_en && !full;
    assign timeout   = (timer == TW'(TIMEOUT - 1));
    assign dbg_state = state;

    always_comb begin
        state_d = state;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (done_rise || timeout) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Storage is left unreset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            transmit  <= 1'b0;
            tx_data   <= 8'h00;
            tx_err    <= 1'b0;
            timer     <= '0;
            tx_done_q <= 1'b0;
        end else begin
            state     <= state_d;
            tx_done_q <= tx_done;
            transmit  <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                tx_data <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (pop) begin
                timer <= '0;
            end else if (state == WAIT_DONE && timer != '1) begin
                timer <= timer + 1'b1;
            end
            // A completion in the timeout cycle wins; a new error beats err_clr.
            if (state == WAIT_DONE && timeout && !done_rise) begin
                tx_err <= 1'b1;
            end else if (err_clr) begin
                tx_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboarded bench for uart_tx_feeder: bytes queued on push are compared
// against tx_data at each transmit pulse, plus timing/boundary checks.
module tb_uart_tx_feeder;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 100;
    localparam int AW      = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          transmit;
    logic [7:0]    tx_data;
    logic          tx_done;
    logic          busy;
    logic          tx_err;
    logic          err_clr;
    logic          dbg_state;
    logic          auto_done;
    logic          man_done;

    logic [7:0]    exp_q[$];
    int            n_checks   = 0;
    int            n_errors   = 0;
    int            n_pulses   = 0;
    int            cyc        = 0;
    int            pulse_cyc  = 0;
    int            resp_delay = 10;
    bit            auto_resp  = 1'b0;
    logic          prev_tx    = 1'b0;

    assign tx_done = auto_done | man_done;

    uart_tx_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .transmit  (transmit),
        .tx_data   (tx_data),
        .tx_done   (tx_done),
        .busy      (busy),
        .tx_err    (tx_err),
        .err_clr   (err_clr),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard: every transmit pulse consumes the oldest expected byte
    initial begin
        forever begin
            @(negedge clk);
            if (transmit) begin
                n_pulses++;
                pulse_cyc = cyc;
                check("tx_single_cycle", prev_tx, 1'b0);
                check("pulse_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("tx_data", tx_data, exp_q.pop_front());
            end
            prev_tx = transmit;
        end
    end

    // uart_top stand-in: raises tx_done resp_delay cycles after a pulse
    initial begin
        auto_done = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_resp && transmit) begin
                repeat (resp_delay) @(posedge clk);
                #1 auto_done = 1'b1;
                @(posedge clk);
                #1 auto_done = 1'b0;
            end
        end
    end

    // driver tasks
    task automatic drive_push(input logic [7:0] b, input bit accept);
        @(posedge clk);
        #1 wr_en = 1'b1;
        wr_data = b;
        if (accept) exp_q.push_back(b);
    endtask

    task automatic release_wr();
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    // Manual tx_done rise; optional push lands on the resulting pop edge.
    task automatic raise_done(input bit do_push, input logic [7:0] b, input bit accept);
        @(posedge clk);
        #1 man_done = 1'b1;
        @(posedge clk);
        #1 man_done = 1'b0;
        if (do_push) begin
            wr_en   = 1'b1;
            wr_data = b;
            if (accept) exp_q.push_back(b);
        end
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_time", (busy == 1'b0 && exp_q.size() == 0), 1);
    endtask

    initial begin
        int pulses_before;
        int n;
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_data  = 8'h00;
        err_clr  = 1'b0;
        man_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_transmit", transmit, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_tx_err", tx_err, 0);
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, 0);

        // single byte, latency and busy release
        auto_resp  = 1'b1;
        resp_delay = 10;
        drive_push(8'hA5, 1'b1);
        release_wr();
        @(negedge clk);
        check("t1_count_after_push", count, 1);
        check("t1_no_early_pulse", transmit, 0);
        @(negedge clk);
        check("t1_pulse_at_n1", transmit, 1);
        check("t1_tx_data", tx_data, 8'hA5);
        check("t1_count_after_pop", count, 0);
        repeat (10) @(negedge clk);
        check("t1_busy_before_done", busy, 1);
        @(negedge clk);
        check("t1_busy_after_done", busy, 0);
        check("t1_pulses", n_pulses, 1);

        // fill to full behind an in-flight byte, overflow drop
        auto_resp = 1'b0;
        drive_push(8'hEE, 1'b1);
        release_wr();
        repeat (2) @(negedge clk);
        check("t2_in_flight", dbg_state, 1);
        for (int i = 0; i < 16; i++) drive_push(8'(i), 1'b1);
        drive_push(8'h55, 1'b0);
        release_wr();
        @(negedge clk);
        check("t2_full", full, 1);
        check("t2_count_full", count, DEPTH);
        check("t2_not_empty", empty, 0);

        // push refused on the pop cycle while full; push+pop keeps count
        raise_done(1'b1, 8'h77, 1'b0);
        @(negedge clk);
        check("t3_refused_count", count, DEPTH - 1);
        check("t3_full_clear", full, 0);
        for (int k = 0; k < 10; k++) raise_done(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check("t3_count_5", count, 5);
        raise_done(1'b1, 8'h88, 1'b1);
        @(negedge clk);
        check("t3_pushpop_count", count, 5);
        auto_resp  = 1'b1;
        resp_delay = $urandom_range(2, 6);
        raise_done(1'b0, 8'h00, 1'b0);
        wait_idle(500);
        @(negedge clk);
        check("t3_total_pulses", n_pulses, 19);
        check("t3_no_err", tx_err, 0);

        // timeout, next byte issued, err_clr, set-beats-clear
        auto_resp = 1'b0;
        drive_push(8'hC1, 1'b1);
        drive_push(8'hC2, 1'b1);
        release_wr();
        n = 0;
        while (tx_err !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("t4_err_set", tx_err, 1);
        check("t4_err_latency", cyc - pulse_cyc, TIMEOUT);
        @(negedge clk);
        check("t4_next_issued", transmit, 1);
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        check("t4_err_cleared", tx_err, 0);
        @(posedge clk);
        #1 err_clr = 1'b1;
        n = 0;
        while (tx_err !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("t4_set_beats_clear", tx_err, 1);
        check("t4_err_latency2", cyc - pulse_cyc, TIMEOUT);
        @(posedge clk);
        #1 err_clr = 1'b0;
        check("t4_err_cleared2", tx_err, 0);
        check("t4_idle", busy, 0);

        // tx_done held high: only a fresh rise completes
        @(posedge clk);
        #1 man_done = 1'b1;
        repeat (2) @(posedge clk);
        drive_push(8'hD1, 1'b1);
        drive_push(8'hD2, 1'b1);
        release_wr();
        repeat (20) @(negedge clk);
        check("t5_held_wait", dbg_state, 1);
        check("t5_held_count", count, 1);
        @(posedge clk);
        #1 man_done = 1'b0;
        @(posedge clk);
        #1 man_done = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_second_out", count, 0);
        repeat (20) @(negedge clk);
        check("t5_held_wait2", dbg_state, 1);
        @(posedge clk);
        #1 man_done = 1'b0;
        @(posedge clk);
        #1 man_done = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_done_idle", busy, 0);
        #1 man_done = 1'b0;

        // reset mid-byte with three queued
        for (int i = 0; i < 4; i++) drive_push(8'hF0 + 8'(i), 1'b1);
        release_wr();
        repeat (3) @(negedge clk);
        check("t6_queued", count, 3);
        check("t6_in_flight", dbg_state, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        check("t6_empty", empty, 1);
        check("t6_count", count, 0);
        check("t6_transmit", transmit, 0);
        check("t6_state", dbg_state, 0);
        check("t6_busy", busy, 0);
        pulses_before = n_pulses;
        repeat (20) @(negedge clk);
        check("t6_no_pulses", n_pulses, pulses_before);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
